smem_token_store: RTL and testbench
===================================

SMEM_TOKEN_STORE -- requirements
Module: smem_token_store

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low.
REQ-003 stall  input  1  pipeline stall from backward-extension pipeline.
REQ-004 wr_curr_valid  input  1; wr_curr_addr  input  7; wr_curr_data  input  256: current-interval write, data packed {info,x2,x1,x0}.
REQ-005 wr_mem_valid  input  1; wr_mem_addr  input  7; wr_mem_data  input  256: SMEM-result write, same packing.
REQ-006 rd_addr  input  7  current-bank read request, issued every non-stalled cycle.
REQ-007 rd_data  output  256; rd_valid  output  1: current-bank read response.
REQ-008 drain_start  input  1; drain_len  input  7: start streaming mem bank entries 0..drain_len-1.
REQ-009 drain_data  output  256; drain_valid  output  1; drain_ready  input  1: drain stream, valid/ready handshake.
REQ-010 drain_busy  output  1; drain_done  output  1 (one-cycle pulse); wr_drop_err  output  1 (sticky).

Function
REQ-011 Two 128x256 banks (curr, mem); write on valid when stall=0; write ignored when stall=1 (upstream holds store_valid during stall, preventing duplicate writes).
REQ-012 Curr read: synchronous, 1-cycle latency; rd_data = curr[rd_addr] sampled in cycle N, presented in N+1 with rd_valid=1.
REQ-013 stall=1: rd_data and rd_valid hold previous values; no new read sampled.
REQ-014 First non-stalled cycle after stall deasserts: read sampled normally, response next cycle.
REQ-015 Same-cycle write and read of the same curr address: behaviour per REQ-026.
REQ-016 Drain FSM states IDLE, READ, HOLD, DONE.
REQ-017 IDLE: drain_start=1 and drain_len!=0 -> READ, latch drain_len, counter=0; drain_len=0 -> DONE directly; drain_start ignored outside IDLE.
REQ-018 READ: issue mem[counter] read; next cycle drain_valid=1 with data -> HOLD.
REQ-019 HOLD: drain_valid stays 1, drain_data stable until drain_ready=1; on handshake counter+1; counter==len-1 -> DONE, else -> READ.
REQ-020 DONE: drain_done=1 for exactly one cycle, drain_valid=0 -> IDLE.
REQ-021 drain_busy=1 in READ, HOLD, DONE.
REQ-022 Drain ignores stall; drain and curr traffic are independent.
REQ-023 wr_mem_valid while drain_busy=1: write dropped, wr_drop_err set until reset.
REQ-024 Addresses 7-bit; counter never wraps (max len 127); no arithmetic beyond counter increment.

Reset
REQ-025 rst=0: rd_data=0, rd_valid=0, drain_data=0, drain_valid=0, drain_busy=0, drain_done=0, wr_drop_err=0, FSM->IDLE, counter=0; RAM contents not reset; reset mid-drain aborts without drain_done.

Configuration
REQ-026 SMEM_STORE_BYPASS_EN defined: curr write-to-read collision on same address returns new wr_curr_data next cycle; undefined: returns old RAM contents (read-before-write).

Structure
REQ-027 Shared package: TOKEN_W=256, ADDR_W=7, DEPTH=128, field offsets X0/X1/X2/INFO, drain state encoding.
REQ-028 One sub-module token_ram (1W1R, sync read, DEPTH x TOKEN_W), instantiated twice.

Verification
REQ-029 Write curr[5]=A, next cycle rd_addr=5 -> rd_data=A, rd_valid=1 one cycle later.
REQ-030 stall=1 three cycles with wr_curr_valid=1 addr 9 -> curr[9] unchanged, rd_data held constant all three cycles.
REQ-031 Write mem[0..3]=M0..M3, drain_start len=4, drain_ready toggling 1,0,1 -> M0..M3 in order, none lost or repeated, drain_done once after M3.
REQ-032 drain_start len=0 -> drain_done pulse two cycles later, drain_valid never asserted.
REQ-033 wr_mem_valid during drain -> mem unchanged, wr_drop_err=1 until rst=0.
REQ-034 Same-cycle write curr[7]=B and rd_addr=7 over old A -> B with SMEM_STORE_BYPASS_EN, A without.

Source files
------------

// File: rtl/smem_token_store_pkg.sv
// Shared widths, token field layout and drain FSM encoding for the SMEM token store.
package smem_token_store_pkg;
  localparam int TOKEN_W  = 256;
  localparam int ADDR_W   = 7;
  localparam int DEPTH    = 128;
  localparam int FIELD_W  = 64;
  localparam int X0_LSB   = 0;
  localparam int X1_LSB   = 64;
  localparam int X2_LSB   = 128;
  localparam int INFO_LSB = 192;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic [FIELD_W-1:0] info;
    logic [FIELD_W-1:0] x2;
    logic [FIELD_W-1:0] x1;
    logic [FIELD_W-1:0] x0;
  } token_t;

  typedef enum logic [1:0] {
    DR_IDLE = 2'd0,
    DR_READ = 2'd1,
    DR_HOLD = 2'd2,
    DR_DONE = 2'd3
  } drain_state_e;
endpackage

// File: rtl/smem_token_store_if.sv
// Bus bundle for the token store: curr/mem write ports, curr read port, drain stream and status.
interface smem_token_store_if;
  import smem_token_store_pkg::*;

  logic   stall;
  logic   wr_curr_valid;
  addr_t  wr_curr_addr;
  token_t wr_curr_data;
  logic   wr_mem_valid;
  addr_t  wr_mem_addr;
  token_t wr_mem_data;
  addr_t  rd_addr;
  token_t rd_data;
  logic   rd_valid;
  logic   drain_start;
  addr_t  drain_len;
  token_t drain_data;
  logic   drain_valid;
  logic   drain_ready;
  logic   drain_busy;
  logic   drain_done;
  logic   wr_drop_err;

  modport master (
    output stall, wr_curr_valid, wr_curr_addr, wr_curr_data,
    output wr_mem_valid, wr_mem_addr, wr_mem_data, rd_addr,
    output drain_start, drain_len, drain_ready,
    input  rd_data, rd_valid, drain_data, drain_valid,
    input  drain_busy, drain_done, wr_drop_err
  );

  modport slave (
    input  stall, wr_curr_valid, wr_curr_addr, wr_curr_data,
    input  wr_mem_valid, wr_mem_addr, wr_mem_data, rd_addr,
    input  drain_start, drain_len, drain_ready,
    output rd_data, rd_valid, drain_data, drain_valid,
    output drain_busy, drain_done, wr_drop_err
  );
endinterface

// File: rtl/smem_token_store_token_ram.sv
// 1W1R token RAM, 1-cycle registered read; read-before-write on same-address collision.
// Output register holds whenever re=0; array contents are not reset.
module token_ram
  import smem_token_store_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   we,
  input  addr_t  waddr,
  input  token_t wdata,
  input  logic   re,
  input  addr_t  raddr,
  output token_t rdata
);
  token_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/smem_token_store.sv
// Curr/mem token banks: curr read 1-cycle latency, frozen by stall; mem drained over valid/ready.
// SMEM_STORE_BYPASS_EN: same-address curr write/read returns the new data instead of old contents.
module smem_token_store
  import smem_token_store_pkg::*;
(
  input logic              clk,
  input logic              rst,
  smem_token_store_if.slave bus
);
  drain_state_e state;
  addr_t        cnt, len_q, cnt_inc;
  logic         busy_q, valid_q, done_q, drop_q, rd_valid_q;
  logic         curr_we, mem_we, mem_re;
  token_t       curr_q, mem_q;

  assign curr_we = bus.wr_curr_valid & ~bus.stall;
  assign mem_we  = bus.wr_mem_valid & ~bus.stall & ~busy_q;
  assign mem_re  = (state == DR_READ);
  assign cnt_inc = cnt + 1'b1;

  token_ram u_curr (
    .clk(clk), .rst(rst), .we(curr_we), .waddr(bus.wr_curr_addr), .wdata(bus.wr_curr_data),
    .re(~bus.stall), .raddr(bus.rd_addr), .rdata(curr_q)
  );

  token_ram u_mem (
    .clk(clk), .rst(rst), .we(mem_we), .waddr(bus.wr_mem_addr), .wdata(bus.wr_mem_data),
    .re(mem_re), .raddr(cnt), .rdata(mem_q)
  );

`ifdef SMEM_STORE_BYPASS_EN
  logic   byp_q;
  token_t byp_dat_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      byp_q     <= 1'b0;
      byp_dat_q <= '0;
    end else if (!bus.stall) begin
      byp_q     <= curr_we && (bus.wr_curr_addr == bus.rd_addr);
      byp_dat_q <= bus.wr_curr_data;
    end
  end

  assign bus.rd_data = byp_q ? byp_dat_q : curr_q;
`else
  assign bus.rd_data = curr_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst)            rd_valid_q <= 1'b0;
    else if (!bus.stall) rd_valid_q <= 1'b1;
  end

  // drain_done is raised on leaving DONE, so it pulses in the first IDLE cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= DR_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        DR_IDLE: begin
          done_q <= 1'b0;
          if (bus.drain_start) begin
            busy_q <= 1'b1;
            if (bus.drain_len != '0) begin
              len_q <= bus.drain_len;
              cnt   <= '0;
              state <= DR_READ;
            end else begin
              state <= DR_DONE;
            end
          end
        end
        DR_READ: begin
          valid_q <= 1'b1;
          state   <= DR_HOLD;
        end
        DR_HOLD: begin
          if (bus.drain_ready) begin
            cnt     <= cnt_inc;
            valid_q <= 1'b0;
            state   <= (cnt_inc == len_q) ? DR_DONE : DR_READ;
          end
        end
        DR_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DR_IDLE;
        end
        default: state <= DR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) drop_q <= 1'b0;
    else if (bus.wr_mem_valid && !bus.stall && busy_q) drop_q <= 1'b1;
  end

  assign bus.rd_valid    = rd_valid_q;
  assign bus.drain_data  = mem_q;
  assign bus.drain_valid = valid_q;
  assign bus.drain_busy  = busy_q;
  assign bus.drain_done  = done_q;
  assign bus.wr_drop_err = drop_q;
endmodule

// File: tb/tb_smem_token_store.sv
// Randomized bench for smem_token_store against a bank-array reference model.
module tb_smem_token_store;
  import smem_token_store_pkg::*;

`ifdef SMEM_STORE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  smem_token_store_if bus();
  smem_token_store dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [255:0] curr_m [128];
  logic [255:0] mem_m  [128];
  logic [255:0] rd_exp;

  function automatic logic [255:0] rand_tok();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference behaviour of one curr-bank cycle: stall freezes everything,
  // otherwise the response is the pre-write contents unless bypass applies.
  function automatic void curr_model(input logic st, input logic wv, input int wa,
                                     input logic [255:0] wd, input int ra);
    if (st) return;
    rd_exp = (BYP && wv && wa == ra) ? wd : curr_m[ra];
    if (wv) curr_m[wa] = wd;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0;
    bus.wr_curr_valid = 1'b0; bus.wr_curr_addr = '0; bus.wr_curr_data = '0;
    bus.wr_mem_valid = 1'b0;  bus.wr_mem_addr = '0;  bus.wr_mem_data = '0;
    bus.rd_addr = '0;
    bus.drain_start = 1'b0; bus.drain_len = '0; bus.drain_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (3) step();
    checks++;
    if ({bus.rd_valid, bus.drain_valid, bus.drain_busy, bus.drain_done, bus.wr_drop_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000",
               {bus.rd_valid, bus.drain_valid, bus.drain_busy, bus.drain_done, bus.wr_drop_err});
    end
    checks++;
    if (bus.rd_data !== 256'h0 || bus.drain_data !== 256'h0) begin
      errors++;
      $display("FAIL reset_data: rd=%h drain=%h required 0", bus.rd_data, bus.drain_data);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rd_valid: got %b required 1", bus.rd_valid);
    end
  endtask

  task automatic fill_banks();
    for (int i = 0; i < 128; i++) begin
      curr_m[i] = rand_tok();
      mem_m[i]  = rand_tok();
      bus.wr_curr_valid = 1'b1; bus.wr_curr_addr = i[6:0]; bus.wr_curr_data = curr_m[i];
      bus.wr_mem_valid  = 1'b1; bus.wr_mem_addr  = i[6:0]; bus.wr_mem_data  = mem_m[i];
      step();
    end
    idle_inputs();
  endtask

  task automatic test_curr_read();
    logic [255:0] a_tok;
    int wa, ra;
    logic wv;
    a_tok = rand_tok();
    bus.wr_curr_valid = 1'b1; bus.wr_curr_addr = 7'd5; bus.wr_curr_data = a_tok; bus.rd_addr = 7'd0;
    curr_model(1'b0, 1'b1, 5, a_tok, 0);
    step();
    bus.wr_curr_valid = 1'b0; bus.rd_addr = 7'd5;
    curr_model(1'b0, 1'b0, 0, '0, 5);
    step();
    checks++;
    if (bus.rd_data !== a_tok || bus.rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL write_then_read: got %h/%b required %h/1", bus.rd_data, bus.rd_valid, a_tok);
    end
    for (int n = 0; n < 60; n++) begin
      ra = $urandom_range(0, 127);
      wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 127);
      wv = 1'($urandom_range(0, 1));
      a_tok = rand_tok();
      bus.wr_curr_valid = wv; bus.wr_curr_addr = wa[6:0]; bus.wr_curr_data = a_tok; bus.rd_addr = ra[6:0];
      curr_model(1'b0, wv, wa, a_tok, ra);
      step();
      checks++;
      if (bus.rd_data !== rd_exp || bus.rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL curr_random[%0d]: got %h/%b required %h/1", n, bus.rd_data, bus.rd_valid, rd_exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [255:0] held, old9, tok;
    int wa, ra;
    logic wv, st;
    bus.rd_addr = 7'd3;
    curr_model(1'b0, 1'b0, 0, '0, 3);
    step();
    held = rd_exp;
    old9 = curr_m[9];
    bus.stall = 1'b1; bus.wr_curr_valid = 1'b1; bus.wr_curr_addr = 7'd9;
    bus.wr_curr_data = ~old9; bus.rd_addr = 7'd9;
    for (int n = 0; n < 3; n++) begin
      curr_model(1'b1, 1'b1, 9, ~old9, 9);
      step();
      checks++;
      if (bus.rd_data !== held || bus.rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h/%b required %h/1", n, bus.rd_data, bus.rd_valid, held);
      end
    end
    bus.stall = 1'b0; bus.wr_curr_valid = 1'b0;
    curr_model(1'b0, 1'b0, 0, '0, 9);
    step();
    checks++;
    if (bus.rd_data !== old9) begin
      errors++;
      $display("FAIL stall_write_ignored: got %h required %h", bus.rd_data, old9);
    end
    for (int n = 0; n < 60; n++) begin
      st = ($urandom_range(0, 2) == 0);
      ra = $urandom_range(0, 127);
      wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 127);
      wv = 1'($urandom_range(0, 1));
      tok = rand_tok();
      bus.stall = st; bus.wr_curr_valid = wv; bus.wr_curr_addr = wa[6:0];
      bus.wr_curr_data = tok; bus.rd_addr = ra[6:0];
      curr_model(st, wv, wa, tok, ra);
      step();
      checks++;
      if (bus.rd_data !== rd_exp || bus.rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_random[%0d]: got %h/%b required %h/1", n, bus.rd_data, bus.rd_valid, rd_exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    logic [255:0] a_tok, b_tok, exp;
    a_tok = rand_tok();
    b_tok = ~a_tok;
    bus.wr_curr_valid = 1'b1; bus.wr_curr_addr = 7'd7; bus.wr_curr_data = a_tok; bus.rd_addr = 7'd0;
    curr_model(1'b0, 1'b1, 7, a_tok, 0);
    step();
    bus.wr_curr_data = b_tok; bus.rd_addr = 7'd7;
    curr_model(1'b0, 1'b1, 7, b_tok, 7);
    step();
    exp = BYP ? b_tok : a_tok;
    checks++;
    if (bus.rd_data !== exp) begin
      errors++;
      $display("FAIL collision: got %h required %h", bus.rd_data, exp);
    end
    bus.wr_curr_valid = 1'b0;
    curr_model(1'b0, 1'b0, 0, '0, 7);
    step();
    checks++;
    if (bus.rd_data !== b_tok) begin
      errors++;
      $display("FAIL collision_after: got %h required %h", bus.rd_data, b_tok);
    end
    idle_inputs();
  endtask

  // Start a drain of len entries and check the stream against mem_m[0..len-1].
  task automatic do_drain(input int len, input int mode);
    logic [255:0] got [$];
    logic [255:0] pd;
    int done_cnt, done_at, vcnt, k, tail;
    logic pv, pr, rdy;
    done_cnt = 0; done_at = -1; vcnt = 0; k = 0; tail = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    bus.drain_start = 1'b1; bus.drain_len = len[6:0];
    step();
    bus.drain_start = 1'b0; bus.drain_len = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (pv && !pr) begin
        checks++;
        if (bus.drain_valid !== 1'b1 || bus.drain_data !== pd) begin
          errors++;
          $display("FAIL drain_hold: got %b/%h required 1/%h", bus.drain_valid, bus.drain_data, pd);
        end
      end
      if (bus.drain_valid === 1'b1) vcnt++;
      if (bus.drain_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
        checks++;
        if (got.size() != len) begin
          errors++;
          $display("FAIL drain_done_early: beats=%0d required %0d", got.size(), len);
        end
      end
      rdy = (mode == 0) ? (k % 3 != 1) : 1'($urandom_range(0, 1));
      k++;
      bus.drain_ready = rdy;
      if (bus.drain_valid === 1'b1 && rdy) got.push_back(bus.drain_data);
      pv = bus.drain_valid; pr = rdy; pd = bus.drain_data;
      step();
      if (done_cnt > 0) begin
        tail++;
        if (tail > 3) break;
      end
    end
    bus.drain_ready = 1'b0;
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL drain_done_count: got %0d required 1", done_cnt);
    end
    checks++;
    if (got.size() != len) begin
      errors++;
      $display("FAIL drain_beats: got %0d required %0d", got.size(), len);
    end
    for (int i = 0; i < got.size() && i < len; i++) begin
      checks++;
      if (got[i] !== mem_m[i]) begin
        errors++;
        $display("FAIL drain_data[%0d]: got %h required %h", i, got[i], mem_m[i]);
      end
    end
    if (len == 0) begin
      checks++;
      if (vcnt != 0 || done_at != 1) begin
        errors++;
        $display("FAIL drain_len0: valid_cycles=%0d done_at=%0d required 0 and 1", vcnt, done_at);
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      mem_m[i] = rand_tok();
      bus.wr_mem_valid = 1'b1; bus.wr_mem_addr = i[6:0]; bus.wr_mem_data = mem_m[i];
      step();
    end
    bus.wr_mem_valid = 1'b0;
    do_drain(4, 0);
    for (int n = 0; n < 3; n++) do_drain($urandom_range(1, 12), 1);
    do_drain(0, 0);
  endtask

  task automatic test_drop();
    int cyc;
    bus.drain_start = 1'b1; bus.drain_len = 7'd6;
    step();
    bus.drain_start = 1'b0;
    step();
    bus.wr_mem_valid = 1'b1; bus.wr_mem_addr = 7'd2; bus.wr_mem_data = ~mem_m[2];
    step();
    bus.wr_mem_valid = 1'b0;
    checks++;
    if (bus.wr_drop_err !== 1'b1) begin
      errors++;
      $display("FAIL drop_err_set: got %b required 1", bus.wr_drop_err);
    end
    bus.drain_ready = 1'b1;
    cyc = 0;
    while (bus.drain_busy === 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    bus.drain_ready = 1'b0;
    checks++;
    if (cyc >= 100) begin
      errors++;
      $display("FAIL drop_drain_timeout: busy=%b required 0", bus.drain_busy);
    end
    repeat (2) step();
    do_drain(6, 1);
    checks++;
    if (bus.wr_drop_err !== 1'b1) begin
      errors++;
      $display("FAIL drop_err_sticky: got %b required 1", bus.wr_drop_err);
    end
  endtask

  task automatic test_reset_mid_drain();
    int dones;
    bus.drain_start = 1'b1; bus.drain_len = 7'd8; bus.drain_ready = 1'b0;
    step();
    bus.drain_start = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.drain_valid !== 1'b1 || bus.drain_busy !== 1'b1) begin
      errors++;
      $display("FAIL middrain_active: got %b/%b required 1/1", bus.drain_valid, bus.drain_busy);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({bus.drain_valid, bus.drain_busy, bus.drain_done, bus.wr_drop_err, bus.rd_valid} !== 5'b0) begin
      errors++;
      $display("FAIL middrain_reset: got %b required 00000",
               {bus.drain_valid, bus.drain_busy, bus.drain_done, bus.wr_drop_err, bus.rd_valid});
    end
    rst = 1'b1;
    dones = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (bus.drain_done === 1'b1 || bus.drain_busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL middrain_no_done: done/busy cycles=%0d required 0", dones);
    end
    do_drain(5, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_exp = '0;
    test_reset();
    fill_banks();
    test_curr_read();
    test_stall();
    test_collision();
    test_drain();
    test_drop();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
